switching_activity_monitor: RTL and testbench

//  Downstream consumer of a power sub-circuit under test: samples the sub-circuit's primary

---
 rtl/switching_activity_monitor.sv | 158 +++++++++++++++
 tb/tb_switching_activity_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/switching_activity_monitor.sv
// switching_activity_monitor
// Samples a sub-circuit's input vector and output bit on each accepted handshake and
// accumulates Hamming toggle counts over a window of WINDOW samples. The first sample of
// a window only primes the history registers.
// Optional feature macro: ACT_SAT_EN (saturating accumulators plus sticky r_sat flag).
module switching_activity_monitor #(
    parameter int unsigned NIN    = 4,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [NIN-1:0]   s_in_vec,
    input  logic             s_out_bit,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [CNT_W-1:0] r_in_toggles,
    output logic [CNT_W-1:0] r_out_toggles,
    output logic             r_sat,
    output logic             busy
);

    localparam int unsigned CNT_SW = $clog2(WINDOW + 1);
`ifdef ACT_SAT_EN
    localparam int unsigned SUM_W  = CNT_W + 1;
`else
    localparam int unsigned SUM_W  = CNT_W;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state;
    logic [NIN-1:0]      prev_in;
    logic                prev_out;
    logic                have_prev;
    logic [CNT_SW-1:0]   sample_cnt;
    logic [CNT_W-1:0]    in_acc;
    logic [CNT_W-1:0]    out_acc;
    logic [NIN-1:0]      diff;
    logic [SUM_W-1:0]    pc;
    logic [SUM_W-1:0]    in_sum;
    logic [SUM_W-1:0]    out_sum;
    logic                accept;
`ifdef ACT_SAT_EN
    logic                sat_q;
`endif

    assign accept = s_valid & s_ready;

    // Candidate accumulator sums for the current sample (one extra carry bit when saturating)
    always_comb begin
        diff = s_in_vec ^ prev_in;
        pc   = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            pc = pc + SUM_W'(diff[i]);
        end
        in_sum  = SUM_W'(in_acc) + pc;
        out_sum = SUM_W'(out_acc) + SUM_W'(s_out_bit ^ prev_out);
    end

    // Window control FSM with registered handshake/status outputs and accumulators
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            r_valid    <= 1'b0;
            busy       <= 1'b0;
            prev_in    <= '0;
            prev_out   <= 1'b0;
            have_prev  <= 1'b0;
            sample_cnt <= '0;
            in_acc     <= '0;
            out_acc    <= '0;
`ifdef ACT_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_acc     <= '0;
                        out_acc    <= '0;
                        sample_cnt <= '0;
                        have_prev  <= 1'b0;
`ifdef ACT_SAT_EN
                        sat_q      <= 1'b0;
`endif
                        state      <= ACCUM;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (have_prev) begin
`ifdef ACT_SAT_EN
                            if (in_sum[CNT_W]) begin
                                in_acc <= '1;
                                sat_q  <= 1'b1;
                            end else begin
                                in_acc <= in_sum[CNT_W-1:0];
                            end
                            if (out_sum[CNT_W]) begin
                                out_acc <= '1;
                                sat_q   <= 1'b1;
                            end else begin
                                out_acc <= out_sum[CNT_W-1:0];
                            end
`else
                            in_acc  <= in_sum;
                            out_acc <= out_sum;
`endif
                        end
                        prev_in    <= s_in_vec;
                        prev_out   <= s_out_bit;
                        have_prev  <= 1'b1;
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == CNT_SW'(WINDOW - 1)) begin
                            state   <= REPORT;
                            s_ready <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (r_ready) begin
                        state   <= IDLE;
                        r_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    r_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Accumulators are frozen outside ACCUM, so they serve directly as the result registers
    assign r_in_toggles  = in_acc;
    assign r_out_toggles = out_acc;
`ifdef ACT_SAT_EN
    assign r_sat = sat_q;
`else
    assign r_sat = 1'b0;
`endif

endmodule

// File: tb/tb_switching_activity_monitor.sv
// Directed bench for switching_activity_monitor: an 8-bit-counter instance and a 4-bit-counter
// instance share all stimulus; expectations for the narrow instance follow ACT_SAT_EN.
module tb_switching_activity_monitor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [3:0] s_in_vec;
    logic       s_out_bit;
    logic       r_ready;

    logic       s_ready_a, r_valid_a, r_sat_a, busy_a;
    logic [7:0] in_tog_a, out_tog_a;
    logic       s_ready_b, r_valid_b, r_sat_b, busy_b;
    logic [3:0] in_tog_b, out_tog_b;

    int n_tests = 0;
    int n_fail  = 0;

    switching_activity_monitor #(.NIN(4), .WINDOW(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_in_vec(s_in_vec), .s_out_bit(s_out_bit),
        .r_valid(r_valid_a), .r_ready(r_ready),
        .r_in_toggles(in_tog_a), .r_out_toggles(out_tog_a), .r_sat(r_sat_a), .busy(busy_a)
    );

    switching_activity_monitor #(.NIN(4), .WINDOW(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_in_vec(s_in_vec), .s_out_bit(s_out_bit),
        .r_valid(r_valid_b), .r_ready(r_ready),
        .r_in_toggles(in_tog_b), .r_out_toggles(out_tog_b), .r_sat(r_sat_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one sample and hold it until the edge where it is accepted
    task automatic send(input logic [3:0] vec, input logic ob);
        int n;
        s_valid   = 1'b1;
        s_in_vec  = vec;
        s_out_bit = ob;
        n = 0;
        while (!s_ready_a && n < 20) begin
            tick();
            n++;
        end
        if (!s_ready_a) check("send_timeout", 32'd0, 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    // Eight back-to-back samples alternating 0000/1111 and 0/1
    task automatic alt_window();
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? 4'b0000 : 4'b1111, (i % 2 == 0) ? 1'b0 : 1'b1);
            if (i == 6) check("rvalid_before_last", 32'(r_valid_a), 32'd0);
        end
    endtask

    logic [3:0] exp_b_in;
    logic       exp_b_sat;

    initial begin
`ifdef ACT_SAT_EN
        exp_b_in  = 4'd15;
        exp_b_sat = 1'b1;
`else
        exp_b_in  = 4'd12;
        exp_b_sat = 1'b0;
`endif
        rst_n = 1'b0; start = 1'b1; s_valid = 1'b0; s_in_vec = '0; s_out_bit = 1'b0; r_ready = 1'b0;

        // 1: reset (start held high must not matter)
        tick(); tick();
        check("rst_s_ready", 32'(s_ready_a), 32'd0);
        check("rst_r_valid", 32'(r_valid_a), 32'd0);
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_r_sat",   32'(r_sat_a),   32'd0);
        check("rst_in",      32'(in_tog_a),  32'd0);
        check("rst_out",     32'(out_tog_a), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy_a), 32'd0);

        // 2: alternating full-toggle window
        pulse_start();
        check("t2_busy",    32'(busy_a),    32'd1);
        check("t2_s_ready", 32'(s_ready_a), 32'd1);
        alt_window();
        check("t2_r_valid", 32'(r_valid_a), 32'd1);
        check("t2_s_ready_off", 32'(s_ready_a), 32'd0);
        check("t2_in",  32'(in_tog_a),  32'd28);
        check("t2_out", 32'(out_tog_a), 32'd7);
        check("t2_sat", 32'(r_sat_a),   32'd0);

        // 5: narrow counters on the same stimulus
        check("t5_in",    32'(in_tog_b),  32'(exp_b_in));
        check("t5_out",   32'(out_tog_b), 32'd7);
        check("t5_sat",   32'(r_sat_b),   32'(exp_b_sat));
        check("t5_valid", 32'(r_valid_b), 32'd1);

        // 4: hold result with r_ready low; start mid-hold is ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("t4_hold_valid", 32'(r_valid_a), 32'd1);
            check("t4_hold_in",    32'(in_tog_a),  32'd28);
            check("t4_hold_out",   32'(out_tog_a), 32'd7);
        end
        start = 1'b0;
        check("t4_hold_s_ready", 32'(s_ready_a), 32'd0);
        // handshake cycle with start asserted: start must be ignored
        r_ready = 1'b1;
        start   = 1'b1;
        tick();
        r_ready = 1'b0;
        start   = 1'b0;
        check("t4_done_valid", 32'(r_valid_a), 32'd0);
        check("t4_done_busy",  32'(busy_a),    32'd0);
        tick();
        check("t4_start_ignored", 32'(busy_a),    32'd0);
        check("t4_no_ready",      32'(s_ready_a), 32'd0);
        pulse_start();
        check("t4_restart", 32'(busy_a), 32'd1);

        // 3: constant samples with two-cycle s_valid gaps (history from test 2 must be dropped)
        for (int i = 0; i < 8; i++) begin
            send(4'b1010, 1'b1);
            if (i < 7) begin
                tick();
                check("t3_gap_ready1", 32'(s_ready_a), 32'd1);
                tick();
                check("t3_gap_ready2", 32'(s_ready_a), 32'd1);
            end
        end
        check("t3_r_valid", 32'(r_valid_a), 32'd1);
        check("t3_in",  32'(in_tog_a),  32'd0);
        check("t3_out", 32'(out_tog_a), 32'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("t3_done_busy", 32'(busy_a), 32'd0);

        // 6: reset mid-window, then a fresh window
        pulse_start();
        send(4'b0000, 1'b0);
        send(4'b1111, 1'b1);
        send(4'b0000, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_busy",    32'(busy_a),    32'd0);
        check("t6_rst_s_ready", 32'(s_ready_a), 32'd0);
        check("t6_rst_in",      32'(in_tog_a),  32'd0);
        check("t6_rst_out",     32'(out_tog_a), 32'd0);
        tick();
        pulse_start();
        alt_window();
        check("t6_r_valid", 32'(r_valid_a), 32'd1);
        check("t6_in",      32'(in_tog_a),  32'd28);
        check("t6_out",     32'(out_tog_a), 32'd7);
        check("t6_b_in",    32'(in_tog_b),  32'(exp_b_in));
        check("t6_b_sat",   32'(r_sat_b),   32'(exp_b_sat));
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("t6_done_valid", 32'(r_valid_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
